// File: rtl/pe_driver_if.sv
// Host/PE-facing signal bundle of the PE driver. The slave modport is the driver;
// the master modport is the host/PE side that feeds it.
interface pe_driver_if #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 32
);
    logic                      cfg_inst_v;
    logic [INST_WIDTH-1:0]     cfg_inst;
    logic                      cfg_data_v;
    logic [2*DATA_WIDTH-1:0]   cfg_data;
    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic                      inst_in_v;
    logic [INST_WIDTH-1:0]     inst_in;
    logic                      din_pe_v;
    logic [2*DATA_WIDTH-1:0]   din_pe;
    logic                      alpha_v;
    logic                      dout_pe_v;
    logic [2*DATA_WIDTH-1:0]   dout_pe;
    logic                      result_v;
    logic [2*DATA_WIDTH-1:0]   result;

    modport master (
        output cfg_inst_v, cfg_inst, cfg_data_v, cfg_data, start, dout_pe_v, dout_pe,
        input  busy, done, err, inst_in_v, inst_in, din_pe_v, din_pe, alpha_v,
               result_v, result
    );

    modport slave (
        input  cfg_inst_v, cfg_inst, cfg_data_v, cfg_data, start, dout_pe_v, dout_pe,
        output busy, done, err, inst_in_v, inst_in, din_pe_v, din_pe, alpha_v,
               result_v, result
    );
endinterface

// File: rtl/pe_driver.sv
// Host-side sequencer for one PE: buffers a program and operands, streams them into
// the PE, times the iterations, flags the last one and captures the first result word.
module pe_driver #(
    parameter int DATA_WIDTH  = 16,
    parameter int INST_WIDTH  = 32,
    parameter int INST_NUM    = 16,
    parameter int DATA_NUM    = 16,
    parameter int ITER_CYCLES = 32,
    parameter int ITER_NUM    = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic       clk,
    input  logic       rst,
    pe_driver_if.slave bus
);
    localparam int WW          = 2 * DATA_WIDTH;
    localparam int IA_W        = (INST_NUM > 1) ? $clog2(INST_NUM) : 1;
    localparam int DA_W        = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam int IC_W        = $clog2(INST_NUM + 1);
    localparam int DC_W        = $clog2(DATA_NUM + 1);
    localparam int RUN_CYCLES  = ITER_NUM * ITER_CYCLES;
    localparam int ALPHA_START = (ITER_NUM - 1) * ITER_CYCLES;
    localparam int RC_W        = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam int TC_W        = $clog2(TIMEOUT + 1);

    localparam logic [IC_W-1:0] INST_FULL = IC_W'(INST_NUM);
    localparam logic [DC_W-1:0] DATA_FULL = DC_W'(DATA_NUM);
    localparam logic [IA_W-1:0] IA_LAST   = IA_W'(INST_NUM - 1);
    localparam logic [DA_W-1:0] DA_LAST   = DA_W'(DATA_NUM - 1);
    localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RUN_CYCLES - 1);
    localparam logic [RC_W-1:0] RC_ALPHA  = RC_W'(ALPHA_START);
    localparam logic [TC_W-1:0] TC_LAST   = TC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SEND_INST, SEND_DATA, RUN, WAIT_RES} state_t;

    state_t                state_reg;
    logic [INST_WIDTH-1:0] inst_mem [INST_NUM];
    logic [WW-1:0]         data_mem [DATA_NUM];
    logic [IC_W-1:0]       inst_cnt_reg;
    logic [DC_W-1:0]       data_cnt_reg;
    logic [IA_W-1:0]       inst_rd_reg;
    logic [DA_W-1:0]       data_rd_reg;
    logic [RC_W-1:0]       run_cnt_reg;
    logic [TC_W-1:0]       wait_cnt_reg;
    logic                  armed_reg;
    logic                  captured_reg;

    logic                  busy_reg;
    logic                  done_reg;
    logic                  err_reg;
    logic                  inst_in_v_reg;
    logic [INST_WIDTH-1:0] inst_in_reg;
    logic                  din_pe_v_reg;
    logic [WW-1:0]         din_pe_reg;
    logic                  alpha_v_reg;
    logic                  result_v_reg;
    logic [WW-1:0]         result_reg;

    logic bufs_full, start_ok, start_bad;
    logic inst_we, data_we, inst_drop, data_drop;
    logic inst_issue, data_issue, capture;
    logic wait_finish, wait_expire;

    // busy_reg is low only in IDLE outside the done cycle, so it gates both the
    // start decision and the config writes.
    always_comb begin
        bufs_full   = (inst_cnt_reg == INST_FULL) && (data_cnt_reg == DATA_FULL);
        start_ok    = bus.start && !busy_reg && bufs_full;
        start_bad   = bus.start && !busy_reg && !bufs_full;
        inst_we     = bus.cfg_inst_v && !busy_reg && !start_ok && (inst_cnt_reg != INST_FULL);
        data_we     = bus.cfg_data_v && !busy_reg && !start_ok && (data_cnt_reg != DATA_FULL);
        inst_drop   = bus.cfg_inst_v && !inst_we;
        data_drop   = bus.cfg_data_v && !data_we;
        inst_issue  = start_ok || (state_reg == SEND_INST);
        data_issue  = (state_reg == SEND_DATA);
        capture     = armed_reg && bus.dout_pe_v;
        wait_finish = (state_reg == WAIT_RES) && captured_reg && (wait_cnt_reg != '0);
        wait_expire = (state_reg == WAIT_RES) && !captured_reg && !capture &&
                      (wait_cnt_reg == TC_LAST);
    end

    always_ff @(posedge clk) begin
        if (inst_we) inst_mem[inst_cnt_reg[IA_W-1:0]] <= bus.cfg_inst;
        if (data_we) data_mem[data_cnt_reg[DA_W-1:0]] <= bus.cfg_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            inst_cnt_reg  <= '0;
            data_cnt_reg  <= '0;
            inst_rd_reg   <= '0;
            data_rd_reg   <= '0;
            run_cnt_reg   <= '0;
            wait_cnt_reg  <= '0;
            armed_reg     <= 1'b0;
            captured_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            inst_in_v_reg <= 1'b0;
            inst_in_reg   <= '0;
            din_pe_v_reg  <= 1'b0;
            din_pe_reg    <= '0;
            alpha_v_reg   <= 1'b0;
            result_v_reg  <= 1'b0;
            result_reg    <= '0;
        end else begin
            done_reg     <= 1'b0;
            result_v_reg <= 1'b0;
            err_reg      <= inst_drop | data_drop | start_bad;
            if (inst_we) inst_cnt_reg <= inst_cnt_reg + IC_W'(1);
            if (data_we) data_cnt_reg <= data_cnt_reg + DC_W'(1);

            if (capture) begin
                result_reg   <= bus.dout_pe;
                result_v_reg <= 1'b1;
                armed_reg    <= 1'b0;
                captured_reg <= 1'b1;
            end

            // Read address runs one entry ahead; the RAM output register is the port.
            if (inst_issue) begin
                inst_in_v_reg <= 1'b1;
                inst_in_reg   <= inst_mem[inst_rd_reg];
                if (inst_rd_reg == IA_LAST) begin
                    inst_rd_reg <= '0;
                    state_reg   <= SEND_DATA;
                end else begin
                    inst_rd_reg <= inst_rd_reg + IA_W'(1);
                    state_reg   <= SEND_INST;
                end
            end else begin
                inst_in_v_reg <= 1'b0;
                inst_in_reg   <= '0;
            end

            if (data_issue) begin
                din_pe_v_reg <= 1'b1;
                din_pe_reg   <= data_mem[data_rd_reg];
                if (data_rd_reg == DA_LAST) begin
                    data_rd_reg <= '0;
                    run_cnt_reg <= '0;
                    state_reg   <= RUN;
                end else begin
                    data_rd_reg <= data_rd_reg + DA_W'(1);
                end
            end else begin
                din_pe_v_reg <= 1'b0;
                din_pe_reg   <= '0;
            end

            case (state_reg)
                IDLE: busy_reg <= start_ok;
                RUN: begin
                    busy_reg    <= 1'b1;
                    alpha_v_reg <= (run_cnt_reg >= RC_ALPHA);
                    if (run_cnt_reg == RC_ALPHA) armed_reg <= 1'b1;
                    if (run_cnt_reg == RC_LAST) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT_RES;
                    end else begin
                        run_cnt_reg <= run_cnt_reg + RC_W'(1);
                    end
                end
                WAIT_RES: begin
                    busy_reg    <= 1'b1;
                    alpha_v_reg <= 1'b0;
                    if (wait_finish || wait_expire) begin
                        done_reg     <= 1'b1;
                        state_reg    <= IDLE;
                        armed_reg    <= 1'b0;
                        captured_reg <= 1'b0;
                        inst_cnt_reg <= '0;
                        data_cnt_reg <= '0;
                        if (wait_expire) err_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + TC_W'(1);
                    end
                end
                default: busy_reg <= 1'b1;
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.inst_in_v = inst_in_v_reg;
    assign bus.inst_in   = inst_in_reg;
    assign bus.din_pe_v  = din_pe_v_reg;
    assign bus.din_pe    = din_pe_reg;
    assign bus.alpha_v   = alpha_v_reg;
    assign bus.result_v  = result_v_reg;
    assign bus.result    = result_reg;
endmodule

// File: tb/tb_pe_driver.sv
// Bench for pe_driver: directed and randomized runs, every output checked each cycle
// against a timeline computed from the offsets relative to the start cycle.
module tb_pe_driver;
    localparam int DW = 16, IW = 32, IN = 16, DN = 16, IC = 32, ITN = 4, TO = 64;
    localparam int S           = IN + DN;
    localparam int RUN_END     = S + ITN * IC;
    localparam int ALPHA_FIRST = RUN_END - IC + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_driver_if #(.DATA_WIDTH(DW), .INST_WIDTH(IW)) bus ();

    pe_driver #(
        .DATA_WIDTH(DW), .INST_WIDTH(IW), .INST_NUM(IN), .DATA_NUM(DN),
        .ITER_CYCLES(IC), .ITER_NUM(ITN), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [IW-1:0]   inst_q [IN];
    logic [2*DW-1:0] data_q [DN];
    logic [2*DW-1:0] model_result = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cfg_inst_v = 1'b0; bus.cfg_inst = '0;
        bus.cfg_data_v = 1'b0; bus.cfg_data = '0;
        bus.start = 1'b0; bus.dout_pe_v = 1'b0; bus.dout_pe = '0;
    endtask

    task automatic check_idle(input string tag, input logic exp_err);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, exp_err);
        chk({tag, "_inst_v"}, bus.inst_in_v, 0);
        chk({tag, "_inst"}, bus.inst_in, 0);
        chk({tag, "_din_v"}, bus.din_pe_v, 0);
        chk({tag, "_din"}, bus.din_pe, 0);
        chk({tag, "_alpha"}, bus.alpha_v, 0);
        chk({tag, "_res_v"}, bus.result_v, 0);
        chk({tag, "_res"}, bus.result, model_result);
    endtask

    task automatic load_inst(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bus.cfg_inst_v = 1'b1; bus.cfg_inst = inst_q[i];
            tick();
            bus.cfg_inst_v = 1'b0;
            chk("load_inst_err", bus.err, 0);
        end
    endtask

    task automatic load_data(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bus.cfg_data_v = 1'b1; bus.cfg_data = data_q[i];
            tick();
            bus.cfg_data_v = 1'b0;
            chk("load_data_err", bus.err, 0);
        end
    endtask

    // c0: first cycle (relative to start) the PE raises dout_pe_v, -1 for never;
    // wk: cycle of a stray start+write while busy, -1 for none (0 = with the start).
    task automatic do_run(input int c0, input bit change, input logic [31:0] base, input int wk);
        int cap, done_k;
        bit capd;
        logic [31:0] cap_val, e_inst, e_din;
        capd = 1'b0;
        cap  = 0;
        if (c0 >= 0) begin
            cap  = (c0 > ALPHA_FIRST) ? c0 : ALPHA_FIRST;
            capd = (cap <= RUN_END + TO - 1);
        end
        cap_val = change ? base + 32'(cap - c0) : base;
        done_k  = capd ? (((cap > RUN_END) ? cap : RUN_END) + 2) : (RUN_END + TO);
        $display("run: c0=%0d change=%0d wk=%0d -> capture=%0d at %0d value %h, done at %0d",
                 c0, change, wk, capd, cap, cap_val, done_k);

        bus.start = 1'b1;
        bus.cfg_data_v = (wk == 0); bus.cfg_data = 32'hDEAD_0000;
        tick();
        bus.start = 1'b0; bus.cfg_data_v = 1'b0;
        for (int k = 1; k <= done_k + 1; k++) begin
            e_inst = '0;
            e_din  = '0;
            if (k <= IN) e_inst = inst_q[k-1];
            if (k > IN && k <= S) e_din = data_q[k-IN-1];
            if (capd && k == cap + 1) model_result = cap_val;
            chk("busy", bus.busy, k <= done_k);
            chk("inst_v", bus.inst_in_v, k <= IN);
            chk("inst", bus.inst_in, e_inst);
            chk("din_v", bus.din_pe_v, k > IN && k <= S);
            chk("din", bus.din_pe, e_din);
            chk("alpha", bus.alpha_v, k >= ALPHA_FIRST && k <= RUN_END);
            chk("result_v", bus.result_v, capd && k == cap + 1);
            chk("result", bus.result, model_result);
            chk("done", bus.done, k == done_k);
            chk("err", bus.err, (k == done_k && !capd) || (wk >= 0 && k == wk + 1));

            bus.dout_pe_v = (c0 >= 0 && k >= c0 && k <= done_k);
            bus.dout_pe   = bus.dout_pe_v ? (change ? base + 32'(k - c0) : base) : 32'h0BAD_0BAD;
            bus.start      = (k == wk);
            bus.cfg_data_v = (k == wk);
            tick();
            bus.start = 1'b0; bus.cfg_data_v = 1'b0;
        end
        bus.dout_pe_v = 1'b0;
    endtask

    task automatic start_rejected(input string tag);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_idle(tag, 1'b1);
        tick();
        check_idle({tag, "_after"}, 1'b0);
    endtask

    task automatic fill_nominal();
        for (int i = 0; i < IN; i++) inst_q[i] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < DN; i++) data_q[i] = 32'h0001_0000 * 32'(i) + 32'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < IN; i++) inst_q[i] = $urandom;
        for (int i = 0; i < DN; i++) data_q[i] = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        #2;
        check_idle("reset", 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check_idle("post_reset", 1'b0);

        // Incomplete buffers: 15 instructions, start together with the 16th write.
        fill_nominal();
        load_inst(0, IN - 2);
        load_data(0, DN - 1);
        bus.start = 1'b1;
        bus.cfg_inst_v = 1'b1; bus.cfg_inst = inst_q[IN-1];
        tick();
        bus.start = 1'b0; bus.cfg_inst_v = 1'b0;
        check_idle("start_incomplete", 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("no_stream", 1'b0);
        end

        // Overflow write in IDLE must be dropped with err.
        bus.cfg_data_v = 1'b1; bus.cfg_data = 32'hFFFF_FFFF;
        tick();
        bus.cfg_data_v = 1'b0;
        chk("overflow_err", bus.err, 1);
        tick();
        chk("overflow_err_clear", bus.err, 0);

        do_run(ALPHA_FIRST + 2, 1'b0, 32'h1234_5678, -1);
        start_rejected("start_after_done");

        fill_random();
        load_inst(0, IN - 1); load_data(0, DN - 1);
        do_run(RUN_END + 10, 1'b0, $urandom, 60);

        fill_random();
        load_inst(0, IN - 1); load_data(0, DN - 1);
        do_run(-1, 1'b0, 32'h0, -1);

        fill_random();
        load_inst(0, IN - 1); load_data(0, DN - 1);
        do_run(ALPHA_FIRST - 5, 1'b1, 32'h5000_0000, 0);

        // Reset during SEND_DATA.
        fill_random();
        load_inst(0, IN - 1); load_data(0, DN - 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < IN + 4; k++) tick();
        chk("pre_reset_din_v", bus.din_pe_v, 1);
        rst = 1'b1;
        #1;
        model_result = '0;
        check_idle("mid_reset", 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check_idle("after_mid_reset", 1'b0);
        start_rejected("start_after_reset");

        fill_nominal();
        load_inst(0, IN - 1); load_data(0, DN - 1);
        do_run(ALPHA_FIRST + 2, 1'b0, 32'h1234_5678, -1);

        for (int r = 0; r < 4; r++) begin
            int c0, wk;
            fill_random();
            load_inst(0, IN - 1); load_data(0, DN - 1);
            c0 = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, RUN_END + TO + 5));
            wk = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, RUN_END));
            do_run(c0, 1'($urandom_range(0, 1)), $urandom, wk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
